// File: rtl/spi_slv16.sv
// ============================================================================
// spi_slv16 : 16-bit SPI slave (SCLK idles high, MSB first, oversampled on clk)
// Revision  : 1.0
// ============================================================================
`default_nettype none

module spi_slv16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] tx_data,
   input  logic        wrt,
   output logic [15:0] rx_data,
   output logic        done
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   state_t      state;
   logic [2:0]  ss_sync;
   logic [2:0]  sclk_sync;
   logic [1:0]  mosi_sync;
   logic [15:0] tx_buf;
   logic [15:0] shft;
   logic [4:0]  bit_cnt;
   logic        mosi_smpl;

   logic ss_fall;
   logic ss_rise;
   logic sclk_rise;
   logic sclk_fall;

   assign ss_fall   =  ss_sync[2]   & ~ss_sync[1];
   assign ss_rise   = ~ss_sync[2]   &  ss_sync[1];
   assign sclk_rise = ~sclk_sync[2] &  sclk_sync[1];
   assign sclk_fall =  sclk_sync[2] & ~sclk_sync[1];

   // Line is released whenever the synchronized select is inactive.
   assign MISO = ss_sync[1] ? 1'bz : shft[15];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= 3'b111;
         sclk_sync <= 3'b111;
         mosi_sync <= 2'b00;
         state     <= IDLE;
         tx_buf    <= 16'h0000;
         shft      <= 16'h0000;
         bit_cnt   <= 5'd0;
         mosi_smpl <= 1'b0;
         rx_data   <= 16'h0000;
         done      <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[1:0], SS_n};
         sclk_sync <= {sclk_sync[1:0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
         done      <= 1'b0;

         if (wrt)
            tx_buf <= tx_data;

         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= ACTIVE;
                  shft    <= wrt ? tx_data : tx_buf;
                  bit_cnt <= 5'd0;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state <= IDLE;
               end else if (bit_cnt != 5'd16) begin
                  // Once 16 bits are in, further SCLK activity is ignored.
                  if (sclk_rise) begin
                     mosi_smpl <= mosi_sync[1];
                     bit_cnt   <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd15) begin
                        rx_data <= {shft[14:0], mosi_sync[1]};
                        done    <= 1'b1;
                     end
                  end else if (sclk_fall && (bit_cnt != 5'd0)) begin
                     shft <= {shft[14:0], mosi_smpl};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
